// File: rtl/vp_pixel_mode_pipe.sv
// Two-stage ready/valid pixel stage: passthrough / grayscale / threshold / invert with raster tagging.
// Optional VP_PIPE_STATS_EN adds frame and stall counters on o_frame_cnt / o_stall_cnt.
module vp_pixel_mode_pipe #(
    parameter int DW = 12,
    parameter int RL = 640,
    parameter int NR = 480
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [1:0]        i_mode,
    input  logic [DW/3-1:0]   i_threshold,
    output logic              o_data_ready,
    input  logic              i_data_valid,
    input  logic [DW-1:0]     i_data,
    input  logic              i_data_ready,
    output logic              o_data_valid,
    output logic [DW-1:0]     o_data,
    output logic              o_sof,
    output logic              o_eol
`ifdef VP_PIPE_STATS_EN
    ,
    output logic [15:0]       o_frame_cnt,
    output logic [15:0]       o_stall_cnt
`endif
);

    localparam int CW = DW / 3;
    localparam int XW = (RL > 1) ? $clog2(RL) : 1;
    localparam int YW = (NR > 1) ? $clog2(NR) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(RL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(NR - 1);

    logic [XW-1:0]  x_reg;
    logic [YW-1:0]  y_reg;
    logic [1:0]     mode_reg;
    logic [CW-1:0]  thr_reg;

    logic           v1_reg, sof1_reg, eol1_reg;
    logic [DW-1:0]  pix1_reg;
    logic           v2_reg, sof2_reg, eol2_reg;
    logic [DW-1:0]  pix2_reg;

    logic           en;
    logic           accept;
    logic           at_origin;
    logic           at_eol;

    assign en           = ~v2_reg | i_data_ready;
    assign o_data_ready = en & i_rstn;
    assign accept       = i_data_valid & o_data_ready;
    assign at_origin    = (x_reg == '0) && (y_reg == '0);
    assign at_eol       = (x_reg == X_LAST);

    // Raster position plus per-frame mode/threshold; the latch fires on the accept of (0,0)
    // so the frame's first pixel already sees the new settings when it is computed in S1.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            x_reg    <= '0;
            y_reg    <= '0;
            mode_reg <= 2'd0;
            thr_reg  <= '0;
        end else if (accept) begin
            if (at_eol) begin
                x_reg <= '0;
                y_reg <= (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
            end else begin
                x_reg <= x_reg + 1'b1;
            end
            if (at_origin) begin
                mode_reg <= i_mode;
                thr_reg  <= i_threshold;
            end
        end
    end

    // S1: capture stage
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            v1_reg   <= 1'b0;
            sof1_reg <= 1'b0;
            eol1_reg <= 1'b0;
            pix1_reg <= '0;
        end else if (en) begin
            v1_reg   <= i_data_valid;
            sof1_reg <= at_origin;
            eol1_reg <= at_eol;
            pix1_reg <= i_data;
        end
    end

    logic [CW-1:0]  r_ch, g_ch, b_ch;
    logic [CW+1:0]  luma_sum;
    logic [CW-1:0]  gray;
    logic [DW-1:0]  gray_pix;
    logic [DW-1:0]  bin_pix;
    logic [DW-1:0]  f_pix;

    assign r_ch     = pix1_reg[DW-1 -: CW];
    assign g_ch     = pix1_reg[2*CW-1 -: CW];
    assign b_ch     = pix1_reg[CW-1:0];
    assign luma_sum = {2'b00, r_ch} + {1'b0, g_ch, 1'b0} + {2'b00, b_ch};
    assign gray     = luma_sum[CW+1:2];
    assign bin_pix  = (gray >= thr_reg) ? {DW{1'b1}} : {DW{1'b0}};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_gray_rep
            assign gray_pix[gi*CW +: CW] = gray;
        end
    endgenerate

    always_comb begin
        f_pix = pix1_reg;
        case (mode_reg)
            2'd1:    f_pix = gray_pix;
            2'd2:    f_pix = bin_pix;
            2'd3:    f_pix = ~pix1_reg;
            default: f_pix = pix1_reg;
        endcase
    end

    // S2: output stage; flags are masked by v1 so they can never appear on a bubble
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            v2_reg   <= 1'b0;
            sof2_reg <= 1'b0;
            eol2_reg <= 1'b0;
            pix2_reg <= '0;
        end else if (en) begin
            v2_reg   <= v1_reg;
            sof2_reg <= v1_reg & sof1_reg;
            eol2_reg <= v1_reg & eol1_reg;
            pix2_reg <= f_pix;
        end
    end

    assign o_data_valid = v2_reg;
    assign o_data       = pix2_reg;
    assign o_sof        = sof2_reg;
    assign o_eol        = eol2_reg;

`ifdef VP_PIPE_STATS_EN
    logic          last1_reg, last2_reg;
    logic [15:0]   frame_cnt_reg;
    logic [15:0]   stall_cnt_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            last1_reg <= 1'b0;
            last2_reg <= 1'b0;
        end else if (en) begin
            last1_reg <= (y_reg == Y_LAST);
            last2_reg <= v1_reg & last1_reg;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            frame_cnt_reg <= 16'd0;
            stall_cnt_reg <= 16'd0;
        end else begin
            if (v2_reg && i_data_ready && eol2_reg && last2_reg)
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            if (v2_reg && !i_data_ready && (stall_cnt_reg != 16'hFFFF))
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign o_frame_cnt = frame_cnt_reg;
    assign o_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_vp_pixel_mode_pipe.sv
// Directed bench for vp_pixel_mode_pipe (DW=12, RL=4, NR=2): modes, backpressure, frame latch, reset.
module tb_vp_pixel_mode_pipe;

    localparam int DW = 12;
    localparam int RL = 4;
    localparam int NR = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [3:0]  thr = 4'd0;
    logic        o_ready;
    logic        in_valid = 1'b0;
    logic [11:0] in_data = 12'h000;
    logic        out_ready = 1'b1;
    logic        o_valid;
    logic [11:0] o_data;
    logic        o_sof;
    logic        o_eol;
`ifdef VP_PIPE_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    vp_pixel_mode_pipe #(.DW(DW), .RL(RL), .NR(NR)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_mode       (mode),
        .i_threshold  (thr),
        .o_data_ready (o_ready),
        .i_data_valid (in_valid),
        .i_data       (in_data),
        .i_data_ready (out_ready),
        .o_data_valid (o_valid),
        .o_data       (o_data),
        .o_sof        (o_sof),
        .o_eol        (o_eol)
`ifdef VP_PIPE_STATS_EN
        ,
        .o_frame_cnt  (frame_cnt),
        .o_stall_cnt  (stall_cnt)
`endif
    );

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int stall_left = 0;
    bit saw_not_ready = 1'b0;

    logic [13:0] exp_q[$];
    logic [13:0] got_q[$];
    int          acc_q[$];
    int          got_cyc_q[$];
    logic [11:0] vi[8];
    logic [11:0] vo[8];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: logs every transfer and watches that stalled outputs stay put.
    bit          prev_stall = 1'b0;
    logic [11:0] prev_data = 12'h000;
    int          hold_checks = 0;
    int          hold_bad = 0;
    always @(negedge clk) begin
        if (prev_stall) begin
            hold_checks++;
            if (!(o_valid === 1'b1 && o_data === prev_data)) hold_bad++;
        end
        if (o_valid === 1'b1 && out_ready) begin
            got_q.push_back({o_data, o_sof, o_eol});
            got_cyc_q.push_back(cyc);
        end
        prev_stall = (o_valid === 1'b1) && !out_ready && rstn;
        prev_data  = o_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        #1;
    endtask

    task automatic send(input logic [11:0] v);
        int  n;
        bit  acc;
        in_data  = v;
        in_valid = 1'b1;
        #1;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 40) begin
            acc = o_ready;
            if (acc) acc_q.push_back(cyc);
            else saw_not_ready = 1'b1;
            tick();
            n++;
        end
        chk($sformatf("accept_%h", v), {31'd0, acc}, 32'd1);
    endtask

    task automatic expect_px(input logic [11:0] d, input logic s, input logic e);
        exp_q.push_back({d, s, e});
    endtask

    // Sends vi[] as one frame with the given settings; settings are scrambled after
    // the sof pixel, which must not affect the rest of the frame.
    task automatic run_frame(input logic [1:0] m, input logic [3:0] t);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                mode = m;
                thr  = t;
            end
            send(vi[i]);
            if (i == 0) begin
                mode = m + 2'd1;
                thr  = t ^ 4'hF;
            end
            expect_px(vo[i], i == 0, (i == 3) || (i == 7));
        end
    endtask

    task automatic drain_and_check(input string tag, input bit lat);
        int n;
        in_valid = 1'b0;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 60) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            nvec++;
            assert (got_q[i] === exp_q[i]) else begin
                nerr++;
                $error("FAIL %s[%0d]: got data=%h sof=%b eol=%b, required data=%h sof=%b eol=%b",
                       tag, i, got_q[i][13:2], got_q[i][1], got_q[i][0],
                       exp_q[i][13:2], exp_q[i][1], exp_q[i][0]);
            end
            if (lat && i < acc_q.size())
                chk($sformatf("%s_latency[%0d]", tag, i), got_cyc_q[i] - acc_q[i], 32'd2);
        end
        exp_q.delete();
        got_q.delete();
        acc_q.delete();
        got_cyc_q.delete();
    endtask

    initial begin
        // Reset state, with upstream already offering data
        in_valid = 1'b1;
        in_data  = 12'hABC;
        tick();
        tick();
        tick();
        chk("rst_ready", {31'd0, o_ready}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_data",  {20'd0, o_data}, 32'd0);
        chk("rst_sof",   {31'd0, o_sof}, 32'd0);
        chk("rst_eol",   {31'd0, o_eol}, 32'd0);
`ifdef VP_PIPE_STATS_EN
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
`endif
        in_valid = 1'b0;
        rstn     = 1'b1;
        tick();

        // Frame 1: passthrough, continuous stream, 2-cycle latency
        mode = 2'd0;
        thr  = 4'd0;
        for (int i = 1; i <= 8; i++) begin
            send(12'(i));
            expect_px(12'(i), i == 1, (i % 4) == 0);
        end
        drain_and_check("mode0", 1'b1);

        // Frame 2: grayscale
        vi = '{12'hF80, 12'hFFF, 12'h000, 12'h123, 12'h0F0, 12'h00F, 12'hF0F, 12'h888};
        vo = '{12'h777, 12'hFFF, 12'h000, 12'h222, 12'h777, 12'h333, 12'h777, 12'h888};
        run_frame(2'd1, 4'd0);
        drain_and_check("gray", 1'b0);

        // Frame 3: threshold 7
        vi = '{12'hF80, 12'h123, 12'h888, 12'h00F, 12'h0F0, 12'h000, 12'hFFF, 12'h777};
        vo = '{12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'hFFF};
        run_frame(2'd2, 4'd7);
        drain_and_check("thr7", 1'b0);

        // Frame 4: threshold 8
        vi = '{12'hF80, 12'h888, 12'hFFF, 12'h777, 12'h999, 12'h0F0, 12'h001, 12'h880};
        vo = '{12'h000, 12'hFFF, 12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000};
        run_frame(2'd2, 4'd8);
        drain_and_check("thr8", 1'b0);

        // Frame 5: invert
        vi = '{12'h0F0, 12'h123, 12'h000, 12'hFFF, 12'hA5A, 12'h001, 12'h800, 12'h3C3};
        vo = '{12'hF0F, 12'hEDC, 12'hFFF, 12'h000, 12'h5A5, 12'hFFE, 12'h7FF, 12'hC3C};
        run_frame(2'd3, 4'd0);
        drain_and_check("invert", 1'b0);

        // Frame 6: passthrough with a 5-cycle downstream stall mid-row
        mode = 2'd0;
        saw_not_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) stall_left = 5;
            send(12'h010 + 12'(i));
            expect_px(12'h010 + 12'(i), i == 1, (i % 4) == 0);
        end
        drain_and_check("bp", 1'b0);
        chk("bp_ready_low", {31'd0, saw_not_ready}, 32'd1);
        chk("bp_hold_checks", hold_checks, 32'd5);
        chk("bp_hold_bad", hold_bad, 32'd0);
`ifdef VP_PIPE_STATS_EN
        chk("stall_cnt", {16'd0, stall_cnt}, 32'd5);
`endif

        // Frames 7+8: mode switched to invert at (2,0); takes effect at next sof
        mode = 2'd0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) mode = 2'd3;
            send(12'h020 + 12'(i));
            expect_px(12'h020 + 12'(i), i == 1, (i % 4) == 0);
        end
        for (int i = 1; i <= 8; i++) begin
            send(12'h030 + 12'(i));
            expect_px(~(12'h030 + 12'(i)), i == 1, (i % 4) == 0);
        end
        drain_and_check("modechg", 1'b0);

        // Reset pulse at pixel (1,1): (0,1) in flight is lost, next pixel is sof
        mode = 2'd0;
        for (int i = 1; i <= 5; i++) send(12'h040 + 12'(i));
        for (int i = 1; i <= 4; i++) expect_px(12'h040 + 12'(i), i == 1, i == 4);
        rstn     = 1'b0;
        in_data  = 12'h046;
        in_valid = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, o_ready}, 32'd0);
        tick();
        chk("midrst_valid", {31'd0, o_valid}, 32'd0);
        chk("midrst_sof",   {31'd0, o_sof}, 32'd0);
`ifdef VP_PIPE_STATS_EN
        chk("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
`endif
        rstn = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            send(12'h050 + 12'(i));
            expect_px(12'h050 + 12'(i), (i == 1) || (i == 9), (i % 4) == 0);
        end
        drain_and_check("postrst", 1'b0);
`ifdef VP_PIPE_STATS_EN
        chk("frame_cnt_2", {16'd0, frame_cnt}, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
